tm_sequencer: RTL and testbench
===============================

TM_SEQUENCER -- requirements
Module: tm_sequencer

Interface
REQ-001 Parameter TAPE_DEPTH, default 16: number of tape cells; tape address width is 4.
REQ-002 Parameter HALT_STATE, default 3'd7: machine state code that terminates a run.
REQ-003 clk100  in  1  single clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 next_btn  in  1  synchronized "next" button level.
REQ-006 done_btn  in  1  synchronized "done" button level.
REQ-007 in_sym  in  2  tape symbol entered during load.
REQ-008 tape_addr  out  4  tape RAM address.
REQ-009 tape_we  out  1  tape RAM write strobe, one cycle.
REQ-010 tape_wdata  out  2  tape RAM write data.
REQ-011 tape_rdata  in  2  tape RAM read data; valid one cycle after tape_addr is presented.
REQ-012 rule_state  out  3  and rule_sym  out  2: combinational rule-table lookup key.
REQ-013 rule_wsym  in  2, rule_move  in  1 (0 = left, 1 = right), rule_next  in  3: rule-table result, same cycle.
REQ-014 head  out  4  current head position.
REQ-015 tm_state  out  3  current machine state.
REQ-016 phase  out  3  FSM state code.
REQ-017 compute_done  out  1  high in HALT.
REQ-018 err  out  1  high in ERROR.

Function
REQ-019 Button edge = level high now and low in the previous cycle; action is taken in the cycle the edge is seen.
REQ-020 FSM states: LOAD, WAIT, READ, EXEC, HALT, ERROR.
REQ-021 LOAD, next edge with load_ptr < TAPE_DEPTH: same cycle tape_we=1, tape_addr=load_ptr, tape_wdata=in_sym; load_ptr increments.
REQ-022 LOAD, next edge with load_ptr == TAPE_DEPTH (tape full): no write, no pointer change.
REQ-023 LOAD, done edge: go to WAIT with head=0 and tm_state=0.
REQ-024 LOAD, next and done edges in the same cycle: the write of REQ-021 is performed, then the machine goes to WAIT.
REQ-025 WAIT, next edge: go to READ; done edges are ignored outside LOAD.
REQ-026 READ (1 cycle): tape_addr=head, tape_we=0; go to EXEC.
REQ-027 EXEC (1 cycle): rule_sym=tape_rdata, rule_state=tm_state; tape_we=1, tape_addr=head, tape_wdata=rule_wsym; tm_state<=rule_next.
REQ-028 EXEC head update: head-1 if rule_move=0, head+1 if rule_move=1.
REQ-029 EXEC exit: to HALT if rule_next == HALT_STATE; otherwise to WAIT.
REQ-030 EXEC boundary: a move left at head=0 or right at head=TAPE_DEPTH-1 goes to ERROR with head unchanged; the write is still performed.
REQ-031 If REQ-029 and REQ-030 both apply, HALT takes priority.
REQ-032 Step latency: next edge -> tape write occurs 2 cycles later; head and tm_state update at the end of that cycle.
REQ-033 Next edges seen during READ or EXEC are dropped.
REQ-034 HALT and ERROR are absorbing: only reset leaves them.
REQ-035 tape_we is never high outside LOAD and EXEC.

Reset
REQ-036 While reset_n is low: phase=LOAD, load_ptr=0, head=0, tm_state=0.
REQ-037 While reset_n is low: tape_we=0, compute_done=0, err=0.
REQ-038 While reset_n is low, the previous-level button registers are set to 1, so a button held through reset deassertion produces no edge.
REQ-039 Reset asserted mid-step (READ or EXEC) aborts the step immediately; no write occurs after assertion.

Structure
REQ-040 Package tm_pkg holds: the phase enum, TAPE_DEPTH, HALT_STATE, and the symbol (2-bit) and state (3-bit) widths.
REQ-041 Sub-module tm_edge_detect (one flop plus AND gate) is instantiated twice, once for next_btn and once for done_btn.
REQ-042 Tape RAM and rule table are external to this block.

Verification
REQ-043 Load: enter 3,1,0,2 with next pulses -> writes addr 0..3 with data 3,1,0,2; load_ptr=4; phase stays LOAD.
REQ-044 Full tape: 17 next pulses -> exactly 16 writes; the 17th produces no tape_we.
REQ-045 Step: load 1,0, press done, then next; rule (0,1) -> (wsym 2, right, next 1) -> write of 2 at addr 0 exactly 2 cycles after the edge; head=1; tm_state=1; phase=WAIT.
REQ-046 Halt: rule_next=7 on a step -> compute_done=1; further next pulses cause no tape_we.
REQ-047 Boundary: head=0 with a left move -> write performed, err=1, head=0.
REQ-048 Reset/edge: next held across reset release -> no write; reset pulsed in EXEC -> all outputs return to REQ-036..REQ-038 values.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared types and constants for the tape-machine sequencer.
// Phase codes, tape geometry and symbol/state widths live here.
package tm_pkg;

    localparam int SYM_W   = 2;
    localparam int STATE_W = 3;
    localparam int ADDR_W  = 4;

    localparam int TAPE_DEPTH = 16;
    localparam logic [STATE_W-1:0] HALT_STATE = 3'd7;

    typedef logic [SYM_W-1:0]   sym_t;
    typedef logic [STATE_W-1:0] state_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef enum logic [2:0] {
        PH_LOAD,
        PH_WAIT,
        PH_READ,
        PH_EXEC,
        PH_HALT,
        PH_ERROR
    } phase_t;

endpackage

// File: rtl/tm_sequencer_if.sv
// Tape RAM port and rule-table lookup bundle between the
// sequencer (master) and the external memories (slave).
interface tm_sequencer_if;
    import tm_pkg::*;

    addr_t  tape_addr;
    logic   tape_we;
    sym_t   tape_wdata;
    sym_t   tape_rdata;
    state_t rule_state;
    sym_t   rule_sym;
    sym_t   rule_wsym;
    logic   rule_move;
    state_t rule_next;

    modport master (
        output tape_addr, tape_we, tape_wdata,
        output rule_state, rule_sym,
        input  tape_rdata,
        input  rule_wsym, rule_move, rule_next
    );

    modport slave (
        input  tape_addr, tape_we, tape_wdata,
        input  rule_state, rule_sym,
        output tape_rdata,
        output rule_wsym, rule_move, rule_next
    );

endinterface

// File: rtl/tm_edge_detect.sv
// Rising-edge detector for an already-synchronized button level.
// The history flop resets high so a held button yields no edge.
module tm_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/tm_sequencer.sv
// Button-driven Turing-machine sequencer: loads a tape, then
// single-steps the machine against an external rule table.
module tm_sequencer #(
    parameter int TAPE_DEPTH = tm_pkg::TAPE_DEPTH,
    parameter logic [2:0] HALT_STATE = tm_pkg::HALT_STATE
) (
    input  logic                clk100,
    input  logic                reset_n,
    input  logic                next_btn,
    input  logic                done_btn,
    input  tm_pkg::sym_t        in_sym,
    tm_sequencer_if.master      tape,
    output tm_pkg::addr_t       head,
    output tm_pkg::state_t      tm_state,
    output logic [2:0]          phase,
    output logic                compute_done,
    output logic                err
);
    import tm_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_P =
        (ADDR_W+1)'(TAPE_DEPTH);
    localparam addr_t LAST = ADDR_W'(TAPE_DEPTH - 1);

    phase_t          ph;
    logic [ADDR_W:0] load_ptr;
    addr_t           head_q;
    state_t          st_q;
    logic            next_edge;
    logic            done_edge;
    logic            load_wr;
    logic            bound;
    logic            halt;

    tm_edge_detect u_next (
        .clk   (clk100),
        .rst_n (reset_n),
        .level (next_btn),
        .pulse (next_edge)
    );

    tm_edge_detect u_done (
        .clk   (clk100),
        .rst_n (reset_n),
        .level (done_btn),
        .pulse (done_edge)
    );

    assign load_wr = (ph == PH_LOAD) && next_edge
                   && (load_ptr < DEPTH_P);
    assign bound = tape.rule_move ? (head_q == LAST)
                                  : (head_q == '0);
    assign halt = (tape.rule_next == HALT_STATE);

    // Loading and stepping share one RAM port.
    always_comb begin
        tape.tape_we    = load_wr || (ph == PH_EXEC);
        tape.tape_addr  = head_q;
        tape.tape_wdata = tape.rule_wsym;
        if (ph == PH_LOAD) begin
            tape.tape_addr  = load_ptr[ADDR_W-1:0];
            tape.tape_wdata = in_sym;
        end
        tape.rule_state = st_q;
        tape.rule_sym   = tape.tape_rdata;
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            ph           <= PH_LOAD;
            load_ptr     <= '0;
            head_q       <= '0;
            st_q         <= '0;
            compute_done <= 1'b0;
            err          <= 1'b0;
        end else begin
            unique case (ph)
                PH_LOAD: begin
                    if (load_wr) load_ptr <= load_ptr + 1'b1;
                    if (done_edge) begin
                        ph     <= PH_WAIT;
                        head_q <= '0;
                        st_q   <= '0;
                    end
                end
                PH_WAIT: if (next_edge) ph <= PH_READ;
                PH_READ: ph <= PH_EXEC;
                PH_EXEC: begin
                    st_q <= tape.rule_next;
                    if (!bound) begin
                        head_q <= tape.rule_move ? head_q + 1'b1
                                                 : head_q - 1'b1;
                    end
                    if (halt) begin
                        ph           <= PH_HALT;
                        compute_done <= 1'b1;
                    end else if (bound) begin
                        ph  <= PH_ERROR;
                        err <= 1'b1;
                    end else begin
                        ph <= PH_WAIT;
                    end
                end
                PH_HALT:  ph <= PH_HALT;
                PH_ERROR: ph <= PH_ERROR;
                default:  ph <= PH_ERROR;
            endcase
        end
    end

    assign head     = head_q;
    assign tm_state = st_q;
    assign phase    = ph;

endmodule

// File: tb/tb_tm_sequencer.sv
// Bench for tm_sequencer: tape RAM and rule ROM models, a per-cycle
// behavioural reference, and directed scenarios with literal checks.
module tb_tm_sequencer;
    import tm_pkg::*;

    logic       clk100 = 1'b0;
    logic       reset_n = 1'b0;
    logic       next_btn = 1'b0;
    logic       done_btn = 1'b0;
    logic [1:0] in_sym = 2'd0;
    logic [3:0] head;
    logic [2:0] tm_state;
    logic [2:0] phase;
    logic       compute_done;
    logic       err;

    tm_sequencer_if bus ();

    tm_sequencer dut (
        .clk100       (clk100),
        .reset_n      (reset_n),
        .next_btn     (next_btn),
        .done_btn     (done_btn),
        .in_sym       (in_sym),
        .tape         (bus.master),
        .head         (head),
        .tm_state     (tm_state),
        .phase        (phase),
        .compute_done (compute_done),
        .err          (err)
    );

    always #5 clk100 = ~clk100;

    int checks = 0;
    int fails = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    // External tape RAM (registered read) and rule ROM.
    logic [1:0] mem [16];
    logic [1:0] r_wsym [32];
    logic       r_move [32];
    logic [2:0] r_next [32];
    int cyc = 0;
    int wr_count = 0;
    int we_cyc = -1;

    always @(posedge clk100) begin
        if (bus.tape_we) begin
            mem[bus.tape_addr] <= bus.tape_wdata;
            wr_count++;
            we_cyc = cyc;
        end
        bus.tape_rdata <= mem[bus.tape_addr];
        cyc++;
    end

    assign bus.rule_wsym = r_wsym[{bus.rule_state, bus.rule_sym}];
    assign bus.rule_move = r_move[{bus.rule_state, bus.rule_sym}];
    assign bus.rule_next = r_next[{bus.rule_state, bus.rule_sym}];

    // Reference machine, advanced once per cycle.
    phase_t     m_ph = PH_LOAD;
    int         m_ptr, m_head, m_st;
    bit         m_pn = 1'b1;
    bit         m_pd = 1'b1;
    logic [1:0] m_tape [16];

    always @(negedge clk100) begin
        bit en, ed, e_we, bnd;
        int e_addr, e_wd, idx;
        if (!reset_n) begin
            m_ph = PH_LOAD;
            m_ptr = 0;
            m_head = 0;
            m_st = 0;
            m_pn = 1'b1;
            m_pd = 1'b1;
            chk("rst_we", bus.tape_we, 0);
            chk("rst_phase", phase, int'(PH_LOAD));
            chk("rst_head", head, 0);
            chk("rst_state", tm_state, 0);
            chk("rst_done", compute_done, 0);
            chk("rst_err", err, 0);
        end else begin
            en = next_btn && !m_pn;
            ed = done_btn && !m_pd;
            e_we = 1'b0;
            e_addr = 0;
            e_wd = 0;
            idx = 0;
            if (m_ph == PH_LOAD && en && m_ptr < 16) begin
                e_we = 1'b1;
                e_addr = m_ptr;
                e_wd = in_sym;
            end
            if (m_ph == PH_READ)
                chk("read_addr", bus.tape_addr, m_head);
            if (m_ph == PH_EXEC) begin
                idx = m_st * 4 + int'(m_tape[m_head]);
                e_we = 1'b1;
                e_addr = m_head;
                e_wd = r_wsym[idx];
                chk("rule_sym", bus.rule_sym, m_tape[m_head]);
                chk("rule_state", bus.rule_state, m_st);
            end
            chk("tape_we", bus.tape_we, e_we);
            if (e_we) begin
                chk("tape_addr", bus.tape_addr, e_addr);
                chk("tape_wdata", bus.tape_wdata, e_wd);
            end
            chk("phase", phase, int'(m_ph));
            chk("head", head, m_head);
            chk("tm_state", tm_state, m_st);
            chk("compute_done", compute_done,
                int'(m_ph == PH_HALT));
            chk("err", err, int'(m_ph == PH_ERROR));
            case (m_ph)
                PH_LOAD: begin
                    if (e_we) begin
                        m_tape[m_ptr] = in_sym;
                        m_ptr++;
                    end
                    if (ed) begin
                        m_ph = PH_WAIT;
                        m_head = 0;
                        m_st = 0;
                    end
                end
                PH_WAIT: if (en) m_ph = PH_READ;
                PH_READ: m_ph = PH_EXEC;
                PH_EXEC: begin
                    m_tape[m_head] = r_wsym[idx];
                    m_st = r_next[idx];
                    bnd = r_move[idx] ? (m_head == 15)
                                      : (m_head == 0);
                    if (!bnd)
                        m_head += r_move[idx] ? 1 : -1;
                    if (m_st == 7) m_ph = PH_HALT;
                    else if (bnd) m_ph = PH_ERROR;
                    else m_ph = PH_WAIT;
                end
                default: ;
            endcase
            m_pn = next_btn;
            m_pd = done_btn;
        end
    end

    task automatic press(input logic [1:0] s);
        @(posedge clk100); #1;
        in_sym = s;
        next_btn = 1'b1;
        @(posedge clk100); #1;
        next_btn = 1'b0;
    endtask

    task automatic press_done();
        @(posedge clk100); #1;
        done_btn = 1'b1;
        @(posedge clk100); #1;
        done_btn = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk100); #1;
        reset_n = 1'b0;
        next_btn = 1'b0;
        done_btn = 1'b0;
        repeat (2) @(posedge clk100);
        #1 reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    int edge_cyc;
    int wc;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 2'd0;
            m_tape[i] = 2'd0;
        end
        for (int i = 0; i < 32; i++) begin
            r_wsym[i] = 2'd0;
            r_move[i] = 1'b1;
            r_next[i] = 3'd0;
        end
        r_wsym[1] = 2'd2; r_move[1] = 1'b1; r_next[1] = 3'd1;
        r_wsym[4] = 2'd3; r_move[4] = 1'b1; r_next[4] = 3'd7;
        r_wsym[2] = 2'd1; r_move[2] = 1'b0; r_next[2] = 3'd3;
        r_wsym[3] = 2'd0; r_move[3] = 1'b0; r_next[3] = 3'd7;

        repeat (2) @(posedge clk100);
        #1 reset_n = 1'b1;

        // Load 3,1,0,2, then fill past the end of the tape.
        wr_count = 0;
        press(2'd3); press(2'd1); press(2'd0); press(2'd2);
        idle(1);
        chk("load_m0", mem[0], 3);
        chk("load_m1", mem[1], 1);
        chk("load_m2", mem[2], 0);
        chk("load_m3", mem[3], 2);
        chk("load_cnt", wr_count, 4);
        chk("load_phase", phase, int'(PH_LOAD));
        for (int i = 4; i < 17; i++) press(2'(i));
        idle(1);
        chk("full_cnt", wr_count, 16);

        // One step, with a next edge landing in EXEC.
        do_reset();
        press(2'd1); press(2'd0); press_done();
        @(posedge clk100); #1;
        next_btn = 1'b1;
        edge_cyc = cyc;
        @(posedge clk100); #1 next_btn = 1'b0;
        @(posedge clk100); #1 next_btn = 1'b1;
        @(posedge clk100); #1 next_btn = 1'b0;
        idle(1);
        chk("step_lat", we_cyc - edge_cyc, 2);
        chk("step_m0", mem[0], 2);
        chk("step_head", head, 1);
        chk("step_state", tm_state, 1);
        chk("step_phase", phase, int'(PH_WAIT));

        // Halt on the following step; later presses are inert.
        press(2'd0);
        idle(3);
        chk("halt_done", compute_done, 1);
        chk("halt_state", tm_state, 7);
        chk("halt_m1", mem[1], 3);
        wc = wr_count;
        press(2'd0); press(2'd0);
        idle(3);
        chk("halt_nowr", wr_count, wc);

        // Left move off cell 0.
        do_reset();
        press(2'd2); press_done(); press(2'd0);
        idle(3);
        chk("bnd_err", err, 1);
        chk("bnd_head", head, 0);
        chk("bnd_m0", mem[0], 1);
        press(2'd0);
        idle(3);

        // Halt outranks the boundary error.
        do_reset();
        press(2'd3); press_done(); press(2'd0);
        idle(3);
        chk("prio_done", compute_done, 1);
        chk("prio_err", err, 0);

        // Next held through reset release.
        @(posedge clk100); #1;
        reset_n = 1'b0;
        next_btn = 1'b1;
        repeat (2) @(posedge clk100);
        #1 reset_n = 1'b1;
        wc = wr_count;
        idle(3);
        next_btn = 1'b0;
        chk("held_nowr", wr_count, wc);

        // Reset asserted during EXEC.
        do_reset();
        press(2'd1); press(2'd0); press_done();
        @(posedge clk100); #1 next_btn = 1'b1;
        @(posedge clk100); #1 next_btn = 1'b0;
        @(posedge clk100); #1;
        wc = wr_count;
        reset_n = 1'b0;
        #1;
        chk("abort_we", bus.tape_we, 0);
        chk("abort_phase", phase, int'(PH_LOAD));
        idle(2);
        chk("abort_m0", mem[0], 1);
        chk("abort_nowr", wr_count, wc);
        reset_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
